axi_sample_loader: RTL

AXI_SAMPLE_LOADER -- requirements
Module: axi_sample_loader

---
 rtl/axi_sample_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_sample_loader.sv
// Streams 16-bit samples into one AXI4 INCR write burst.
// A small FIFO decouples sample intake from the W channel.
module axi_sample_loader #(
   parameter int ID_W_WIDTH = 2,
   parameter int AW_ID      = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_start,
   input  logic [11:0]           i_base_addr,
   input  logic [7:0]            i_len,
   input  logic [15:0]           i_s_data,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   output logic [11:0]           o_AWADDR,
   output logic [7:0]            o_AWLEN,
   output logic [2:0]            o_AWSIZE,
   output logic [1:0]            o_AWBURST,
   output logic [ID_W_WIDTH-1:0] o_AWID,
   output logic                  o_AWVALID,
   input  logic                  i_AWREADY,
   output logic [15:0]           o_WDATA,
   output logic [1:0]            o_WSTRB,
   output logic                  o_WVALID,
   output logic                  o_WLAST,
   input  logic                  i_WREADY,
   input  logic                  i_BVALID,
   input  logic [ID_W_WIDTH-1:0] i_BID,
   output logic                  o_BREADY,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ID_W_WIDTH-1:0] AW_ID_L = ID_W_WIDTH'(AW_ID);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

   state_t           state_q, state_d;
   logic [11:0]      base_q, base_d;
   logic [7:0]       len_q, len_d;
   logic [8:0]       in_cnt_q, in_cnt_d;
   logic [8:0]       out_cnt_q, out_cnt_d;
   logic             err_q, err_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [15:0]      fifo_mem [FIFO_DEPTH];

   logic fifo_full, fifo_empty, s_ready, push, pop, w_valid, w_last;

   always_comb begin
      fifo_full  = (count_q == FULL_CNT);
      fifo_empty = (count_q == '0);
      s_ready    = ((state_q == ADDR) || (state_q == DATA)) && !fifo_full &&
                   (in_cnt_q <= {1'b0, len_q});
      push       = s_ready && i_s_valid;
      w_valid    = (state_q == DATA) && !fifo_empty;
      pop        = w_valid && i_WREADY;
      w_last     = w_valid && (out_cnt_q == {1'b0, len_q});
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      err_d     = err_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               base_d    = i_base_addr;
               len_d     = i_len;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               err_d     = 1'b0;
               state_d   = ADDR;
            end
         end
         ADDR: if (i_AWREADY) state_d = DATA;
         DATA: if (pop && w_last) state_d = RESP;
         RESP: begin
            if (i_BVALID) begin
               state_d = DONE;
               if (i_BID != AW_ID_L) err_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // push/pop only happen in ADDR/DATA, so they never collide with the IDLE clears
      if (push) begin
         in_cnt_d = in_cnt_q + 9'd1;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         out_cnt_d = out_cnt_q + 9'd1;
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage needs no reset: reset empties the FIFO through the pointers and count
   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= i_s_data;
   end

   always_comb begin
      o_s_ready = s_ready;
      o_AWADDR  = base_q;
      o_AWLEN   = len_q;
      o_AWSIZE  = 3'b001;
      o_AWBURST = 2'b01;
      o_AWID    = AW_ID_L;
      o_AWVALID = (state_q == ADDR);
      o_WDATA   = w_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
      o_WSTRB   = 2'b11;
      o_WVALID  = w_valid;
      o_WLAST   = w_last;
      o_BREADY  = (state_q == RESP);
      o_busy    = (state_q != IDLE);
      o_done    = (state_q == DONE);
      o_err     = err_q;
   end

endmodule
